// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access controller.
// Holds the controller state encoding, the error-flag bit positions, the
// status-byte layout sent at the start of every frame, and the filler byte
// returned when a register read times out.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_DATA = 3'd2,
        WR_WAIT = 3'd3,
        RD_WAIT = 3'd4,
        RD_HOLD = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    // Sticky error flag positions inside err[1:0].
    localparam int ERR_TMO = 0;
    localparam int ERR_OVR = 1;

    // Byte shifted out in place of read data when the bus never acknowledges.
    localparam logic [7:0] RD_TMO_FILL = 8'hFF;

    // First byte of every frame: the sticky error flags, zero-padded.
    function automatic logic [7:0] status_byte(input logic [1:0] err);
        return {6'b0, err};
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Register-bus acknowledge timeout counter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : pulse in the cycle a bus request is raised; counter restarts at 0
//   ack      : bus completion pulse; stops the counter
//   expire   : high in the last allowed cycle of a request (TMO cycles total)
module bus_timer #(
    parameter int unsigned TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TMO - 1);

    logic [7:0] cnt_q;
    logic       running_q;

    // The counter holds k in the k-th cycle of the request, so expiring at
    // TMO-1 keeps the request up for exactly TMO cycles.
    assign expire = running_q && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            running_q <= 1'b0;
        end else if (start) begin
            cnt_q     <= 8'd0;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (ack || expire) begin
                running_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI slave register-access controller.
// Frame: status byte out, command byte in ({dir, addr}), then data bytes.
// dir=1 writes each following byte to consecutive addresses; dir=0 reads
// consecutive addresses, one per byte clocked by the master.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   frame_start/frame_end : SPI select edges (one-cycle pulses)
//   rx_valid, rx_byte     : received byte from the SPI byte engine
//   tx_byte, tx_load      : next byte to shift out, with load pulse
//   reg_addr/wdata/we/re  : register bus request, held until ack or timeout
//   reg_rdata, reg_ack    : register bus response
//   busy                  : controller not idle
//   err                   : sticky flags [0] bus timeout, [1] rx overrun
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned TMO    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_ack,
    output logic              busy,
    output logic [1:0]        err
);

    state_e            state_q, state_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [1:0]        err_q, err_d;
    logic              frame_q, frame_d;

    logic              timer_start;
    logic              expire;
    logic              bus_done;
    logic              bus_tmo;
    logic [ADDR_W-1:0] addr_inc;

    bus_timer #(
        .TMO(TMO)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .ack   (reg_ack),
        .expire(expire)
    );

    assign bus_done = (we_q || re_q) && reg_ack;
    // Ack in the final cycle still counts as completion.
    assign bus_tmo  = expire && !reg_ack;
    assign addr_inc = addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        tx_load_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        re_d        = re_q;
        err_d       = err_q;
        timer_start = 1'b0;

        // Tracks select independently of state so DRAIN can wait out a frame.
        if (frame_start) begin
            frame_d = 1'b1;
        end else if (frame_end) begin
            frame_d = 1'b0;
        end else begin
            frame_d = frame_q;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = CMD;
                    tx_byte_d = status_byte(err_q);
                    tx_load_d = 1'b1;
                    err_d     = 2'b00;  // status byte read clears flags
                end
            end

            CMD: begin
                if (rx_valid) begin
                    addr_d = rx_byte[ADDR_W-1:0];
                    if (rx_byte[7]) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d     = RD_WAIT;
                        re_d        = 1'b1;
                        timer_start = 1'b1;
                    end
                end
                // A request raised this cycle must still run to completion.
                if (frame_end) state_d = timer_start ? DRAIN : IDLE;
            end

            WR_DATA: begin
                if (rx_valid) begin
                    wdata_d     = rx_byte;
                    we_d        = 1'b1;
                    timer_start = 1'b1;
                    state_d     = WR_WAIT;
                end
                if (frame_end) state_d = timer_start ? DRAIN : IDLE;
            end

            WR_WAIT: begin
                if (rx_valid) err_d[ERR_OVR] = 1'b1;
                if (bus_done) begin
                    we_d    = 1'b0;
                    addr_d  = addr_inc;
                    state_d = WR_DATA;
                end else if (bus_tmo) begin
                    we_d           = 1'b0;
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = DRAIN;
                end
                if (frame_end) state_d = DRAIN;
            end

            RD_WAIT: begin
                if (rx_valid) err_d[ERR_OVR] = 1'b1;
                if (bus_done) begin
                    re_d    = 1'b0;
                    addr_d  = addr_inc;
                    state_d = RD_HOLD;
                    if (!frame_end) begin
                        tx_byte_d = reg_rdata;
                        tx_load_d = 1'b1;
                    end
                end else if (bus_tmo) begin
                    re_d           = 1'b0;
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = DRAIN;
                    if (!frame_end) begin
                        tx_byte_d = RD_TMO_FILL;
                        tx_load_d = 1'b1;
                    end
                end
                if (frame_end) state_d = DRAIN;
            end

            RD_HOLD: begin
                if (rx_valid) begin
                    re_d        = 1'b1;
                    timer_start = 1'b1;
                    state_d     = RD_WAIT;
                end
                if (frame_end) state_d = timer_start ? DRAIN : IDLE;
            end

            DRAIN: begin
                if (bus_done) begin
                    we_d   = 1'b0;
                    re_d   = 1'b0;
                    addr_d = addr_inc;
                end else if (bus_tmo) begin
                    we_d           = 1'b0;
                    re_d           = 1'b0;
                    err_d[ERR_TMO] = 1'b1;
                end
                if (!frame_q && !frame_start && !we_q && !re_q) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_byte_q <= 8'h00;
            tx_load_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            err_q     <= 2'b00;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
            tx_load_q <= tx_load_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            err_q     <= err_d;
            frame_q   <= frame_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_load   = tx_load_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios with literal
// expectations, then randomized frames against a transaction-level model.
module tb_spi_reg_ctrl;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned TMO    = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0, frame_end = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       busy;
    logic [1:0] err;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .ADDR_W(ADDR_W),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .tx_load    (tx_load),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .busy       (busy),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Model: a frame transaction is "open" from its status byte until it is
    // fully retired; m_req is the outstanding bus request (0 none, 1 wr, 2 rd).
    bit         m_open, m_cmd, m_wr, m_drain, m_frame, m_txload;
    int         m_req, m_wait;
    logic [6:0] m_addr;
    logic [7:0] m_wdata, m_tx;
    logic [1:0] m_err;

    int         cur_lat, fixed_lat;
    bit         rnd_lat;
    logic [7:0] rd_q[$];
    logic [15:0] wlog[$];
    logic [6:0] rlog[$];
    logic [7:0] txlog[$];
    int         we_cycles;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_cmd = 0; m_wr = 0; m_drain = 0; m_frame = 0; m_txload = 0;
        m_req = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_tx = '0; m_err = '0;
    endtask

    task automatic model_step(input bit fs, input bit fe, input bit rv, input logic [7:0] rb,
                              input bit ack, input logic [7:0] rd);
        bit done, tmo, frame_was, started;
        int req_was;
        done      = (m_req != 0) && ack;
        tmo       = (m_req != 0) && !ack && (m_wait == int'(TMO) - 1);
        frame_was = m_frame;
        req_was   = m_req;
        started   = 0;
        m_txload  = 0;
        if (fs) m_frame = 1;
        else if (fe) m_frame = 0;
        if (m_req != 0 && !done && !tmo) m_wait++;
        if (!m_open) begin
            if (fs) begin
                m_open = 1; m_cmd = 0; m_drain = 0;
                m_tx = {6'b0, m_err}; m_txload = 1; m_err = 2'b00;
            end
        end else if (m_drain) begin
            if (done) begin m_addr++; m_req = 0; end
            else if (tmo) begin m_req = 0; m_err[0] = 1'b1; end
            if (!frame_was && !fs && req_was == 0) begin m_open = 0; m_drain = 0; end
        end else if (req_was != 0) begin
            if (rv) m_err[1] = 1'b1;
            if (done) begin
                m_addr++; m_req = 0;
                if (req_was == 2 && !fe) begin m_tx = rd; m_txload = 1; end
            end else if (tmo) begin
                m_req = 0; m_err[0] = 1'b1; m_drain = 1;
                if (req_was == 2 && !fe) begin m_tx = 8'hFF; m_txload = 1; end
            end
            if (fe) m_drain = 1;
        end else begin
            if (rv) begin
                if (!m_cmd) begin
                    m_cmd = 1; m_addr = rb[6:0]; m_wr = rb[7]; started = !rb[7];
                end else begin
                    started = 1;
                    if (m_wr) m_wdata = rb;
                end
                if (started) begin
                    m_req  = m_wr ? 1 : 2;
                    m_wait = 0;
                    if (rnd_lat)
                        cur_lat = ($urandom_range(0, 4) == 0) ? int'(TMO) + 1
                                                              : int'($urandom_range(0, TMO - 1));
                    else
                        cur_lat = fixed_lat;
                end
            end
            if (fe) begin
                if (started) m_drain = 1;
                else m_open = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("tx_byte", tx_byte, m_tx);
        check("tx_load", tx_load, m_txload);
        check("reg_addr", reg_addr, m_addr);
        check("reg_wdata", reg_wdata, m_wdata);
        check("reg_we", reg_we, m_req == 1);
        check("reg_re", reg_re, m_req == 2);
        check("busy", busy, m_open);
        check("err", err, m_err);
    endtask

    // Drive one cycle of inputs (slave ack from the model's request age),
    // advance the model, then compare just after the clock edge.
    task automatic step(input bit fs, input bit fe, input bit rv, input logic [7:0] rb);
        bit ack;
        logic [7:0] rd;
        ack = (m_req != 0) && (m_wait == cur_lat);
        rd  = 8'($urandom);
        if (ack && rd_q.size() > 0) rd = rd_q.pop_front();
        frame_start = fs; frame_end = fe; rx_valid = rv; rx_byte = rb;
        reg_ack = ack; reg_rdata = rd;
        if (ack && reg_we) wlog.push_back({1'b0, reg_addr, reg_wdata});
        if (ack && reg_re) rlog.push_back(reg_addr);
        model_step(fs, fe, rv, rb, ack, rd);
        @(posedge clk);
        #1;
        if (reg_we) we_cycles++;
        if (tx_load) txlog.push_back(tx_byte);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    task automatic clear_logs();
        wlog.delete(); rlog.delete(); txlog.delete(); we_cycles = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_byte"}, tx_byte, 8'h00);
        check({tag, "_tx_load"}, tx_load, 1'b0);
        check({tag, "_reg_addr"}, reg_addr, 7'h00);
        check({tag, "_reg_wdata"}, reg_wdata, 8'h00);
        check({tag, "_reg_we"}, reg_we, 1'b0);
        check({tag, "_reg_re"}, reg_re, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 2'b00);
    endtask

    initial begin
        bit fs, fe, rv;
        logic [7:0] rb;
        model_reset();
        rnd_lat = 0; fixed_lat = -1; cur_lat = -1;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Write burst: 0x11 @ 0x05, 0x22 @ 0x06.
        fixed_lat = 2;
        clear_logs();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h85);
        step(0, 0, 1, 8'h11);
        idle(4);
        step(0, 0, 1, 8'h22);
        idle(4);
        step(0, 1, 0, 8'h00);
        idle(2);
        check("wr_count", 16'(wlog.size()), 16'd2);
        if (wlog.size() == 2) begin
            check("wr0", wlog[0], 16'h0511);
            check("wr1", wlog[1], 16'h0622);
        end
        check("wr_status", txlog.size() > 0 ? txlog[0] : 8'hEE, 8'h00);
        check("wr_err", err, 2'b00);
        check("wr_idle", busy, 1'b0);

        // Read burst wrapping 0x7F -> 0x00.
        fixed_lat = 2;
        clear_logs();
        rd_q.push_back(8'hAA);
        rd_q.push_back(8'hBB);
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h7F);
        idle(4);
        step(0, 0, 1, 8'h00);
        idle(4);
        step(0, 0, 1, 8'h00);
        idle(4);
        step(0, 1, 0, 8'h00);
        idle(3);
        check("rd_count", 16'(rlog.size()), 16'd3);
        if (rlog.size() >= 2) begin
            check("rd_addr0", rlog[0], 7'h7F);
            check("rd_addr1", rlog[1], 7'h00);
        end
        check("tx_count", 16'(txlog.size()), 16'd4);
        if (txlog.size() >= 3) begin
            check("rd_tx0", txlog[1], 8'hAA);
            check("rd_tx1", txlog[2], 8'hBB);
        end

        // Write never acknowledged: request held TMO cycles, err[0] sticky.
        fixed_lat = -1;
        clear_logs();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h81);
        step(0, 0, 1, 8'h5A);
        idle(20);
        check("tmo_we_cycles", 16'(we_cycles), 16'd15);
        check("tmo_err", err, 2'b01);
        step(0, 1, 0, 8'h00);
        idle(3);
        check("tmo_idle", busy, 1'b0);
        step(1, 0, 0, 8'h00);
        check("tmo_status", tx_byte, 8'h01);
        check("tmo_status_load", tx_load, 1'b1);
        check("tmo_err_clr", err, 2'b00);

        // Overrun during WR_WAIT in the same frame: byte dropped, one write.
        fixed_lat = 4;
        clear_logs();
        step(0, 0, 1, 8'h90);
        step(0, 0, 1, 8'h33);
        step(0, 0, 1, 8'h44);
        idle(6);
        step(0, 1, 0, 8'h00);
        idle(2);
        check("ovr_count", 16'(wlog.size()), 16'd1);
        if (wlog.size() == 1) check("ovr_wr", wlog[0], 16'h1033);
        check("ovr_err", err, 2'b10);

        // Frame ends while a read waits: drain with no tx_load.
        fixed_lat = 5;
        clear_logs();
        step(1, 0, 0, 8'h00);
        check("drn_status", tx_byte, 8'h02);
        clear_logs();
        step(0, 0, 1, 8'h20);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check("drn_busy", busy, 1'b1);
        idle(8);
        check("drn_no_load", 16'(txlog.size()), 16'd0);
        check("drn_rd_count", 16'(rlog.size()), 16'd1);
        if (rlog.size() == 1) check("drn_rd_addr", rlog[0], 7'h20);
        check("drn_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a write request.
        fixed_lat = -1;
        clear_logs();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h83);
        step(0, 0, 1, 8'h77);
        step(0, 0, 1, 8'h55);
        idle(2);
        check("pre_rst_we", reg_we, 1'b1);
        check("pre_rst_err", err, 2'b10);
        frame_start = 0; frame_end = 0; rx_valid = 0; reg_ack = 0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Randomized frames.
        rnd_lat = 1;
        for (int i = 0; i < 4000; i++) begin
            fs = 0; fe = 0; rv = 0;
            rb = 8'($urandom);
            if (!m_frame) begin
                fs = ($urandom_range(0, 5) == 0);
            end else begin
                rv = ($urandom_range(0, 2) == 0);
                fe = ($urandom_range(0, 15) == 0);
            end
            step(fs, fe, rv, rb);
        end
        idle(TMO + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
